// File: rtl/uart_rx_core_if.sv
// Parallel side of the UART receiver: serial input, frame configuration and
// the received byte with its status pulses.
interface uart_rx_core_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
);
  logic                   rx_in;
  logic                   par_en;
  logic                   par_typ;
  logic [PRESC_WIDTH-1:0] prescale;
  logic [DATA_WIDTH-1:0]  p_data;
  logic                   data_valid;
  logic                   par_err;
  logic                   stp_err;

  modport master (
    output rx_in, par_en, par_typ, prescale,
    input  p_data, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, par_en, par_typ, prescale,
    output p_data, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver running on an oversampling clock: 3-sample majority per bit,
// optional parity, registered byte output with valid / parity / stop pulses.
module uart_rx_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input logic            clk,
  input logic            rst_n,
  uart_rx_core_if.slave  bus
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]          BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [PRESC_WIDTH-1:0] ONE      = PRESC_WIDTH'(1);
  localparam logic [PRESC_WIDTH-1:0] TWO      = PRESC_WIDTH'(2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [PRESC_WIDTH-1:0] edge_cnt;
  logic [PRESC_WIDTH-1:0] pres_l;
  logic [BW-1:0]          bit_cnt;
  logic                   par_en_l;
  logic                   par_typ_l;
  logic                   par_bad;
  logic                   bit_val;
  logic [2:0]             samples;
  logic [DATA_WIDTH-1:0]  shreg;

  logic [PRESC_WIDTH-1:0] half;
  logic                   at_last;
  logic                   at_resolve;
  logic                   sample_now;
  logic                   maj;

  // Sample points sit around mid-bit; the majority settles two edges past centre.
  assign half       = pres_l >> 1;
  assign at_last    = (edge_cnt == pres_l - ONE);
  assign at_resolve = (edge_cnt == half + TWO);
  assign sample_now = (edge_cnt == half - ONE) || (edge_cnt == half) || (edge_cnt == half + ONE);
  assign maj        = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      edge_cnt       <= '0;
      pres_l         <= '0;
      bit_cnt        <= '0;
      par_en_l       <= 1'b0;
      par_typ_l      <= 1'b0;
      par_bad        <= 1'b0;
      bit_val        <= 1'b1;
      samples        <= '0;
      shreg          <= '0;
      bus.p_data     <= '0;
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= at_last ? '0 : edge_cnt + ONE;
        if (sample_now)
          samples <= {samples[1:0], bus.rx_in};
        if (at_resolve)
          bit_val <= maj;
      end

      case (state)
        IDLE: begin
          // The detection cycle counts as edge 0 of the start bit.
          if (!bus.rx_in) begin
            state     <= START;
            edge_cnt  <= ONE;
            pres_l    <= bus.prescale;
            par_en_l  <= bus.par_en;
            par_typ_l <= bus.par_typ;
            par_bad   <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        START: begin
          if (at_resolve && maj) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (at_last) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (at_last) begin
            shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= par_en_l ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
          if (at_last) begin
            par_bad <= (bit_val != (^shreg ^ par_typ_l));
            state   <= STOP;
          end
        end
        STOP: begin
          // A bad frame leaves the previously delivered byte untouched.
          if (at_last) begin
            state <= IDLE;
            if (bit_val && !par_bad) begin
              bus.p_data     <= shreg;
              bus.data_valid <= 1'b1;
            end
            bus.par_err <= par_bad;
            bus.stp_err <= !bit_val;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus random frames
// compared against a frame-level reference model with exact pulse timing.
module tb_uart_rx_core;

  localparam int DW = 8;
  localparam int PW = 6;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   last_start = 0;
  logic [7:0] last_good = 8'h00;
  ev_t  got_q[$];
  ev_t  exp_q[$];

  always #5 clk = ~clk;

  uart_rx_core_if #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) bus ();

  uart_rx_core #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (bus.data_valid || bus.par_err || bus.stp_err) begin
      ev_t e;
      e.cyc = cyc;
      e.dv  = bus.data_valid;
      e.pe  = bus.par_err;
      e.se  = bus.stp_err;
      e.pd  = bus.p_data;
      got_q.push_back(e);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_in = 1'b1;
    end
  endtask

  // Drives one whole frame and queues the outcome the receiver must report.
  task automatic applyStimulus(input logic [7:0] data, input int p, input bit pen, input bit ptyp,
                               input bit par_flip, input bit stop_val, input bit noisy, input bit scramble);
    logic [11:0] bits;
    int   nb;
    int   half;
    int   nk;
    logic pbit;
    ev_t  e;
    pbit = (($countones(data) % 2) == 1) ^ ptyp ^ par_flip;
    nb   = 2 + DW + (pen ? 1 : 0);
    half = p / 2;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1 + i] = data[i];
    if (pen) bits[DW + 1] = pbit;
    bits[nb - 1] = stop_val;

    e.pe = pen && par_flip;
    e.se = !stop_val;
    e.dv = !e.pe && !e.se;
    if (e.dv) last_good = data;
    e.pd = last_good;

    for (int b = 0; b < nb; b++) begin
      nk = noisy ? (half - 1 + int'($urandom_range(0, 2))) : -1;
      for (int k = 0; k < p; k++) begin
        @(negedge clk);
        if (b == 0 && k == 0) begin
          bus.prescale = PW'(p);
          bus.par_en   = pen;
          bus.par_typ  = ptyp;
          last_start   = cyc;
        end else if (b == 0 && k == 1 && scramble) begin
          bus.prescale = PW'($urandom_range(1, 63));
          bus.par_en   = 1'($urandom);
          bus.par_typ  = 1'($urandom);
        end
        bus.rx_in = bits[b] ^ (k == nk);
      end
    end
    e.cyc = last_start + nb * p;
    exp_q.push_back(e);
  endtask

  task automatic checkEvents(input string tag);
    int n;
    idle(3);
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_cyc"}, got_q[i].cyc, exp_q[i].cyc);
      checkOutput({tag, "_valid"}, got_q[i].dv, exp_q[i].dv);
      checkOutput({tag, "_par_err"}, got_q[i].pe, exp_q[i].pe);
      checkOutput({tag, "_stp_err"}, got_q[i].se, exp_q[i].se);
      checkOutput({tag, "_p_data"}, got_q[i].pd, exp_q[i].pd);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int p;
    int gap;
    bit pen;

    bus.rx_in    = 1'b1;
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    bus.prescale = PW'(8);
    repeat (3) @(negedge clk);
    checkOutput("reset_p_data", bus.p_data, 8'h00);
    checkOutput("reset_valid", bus.data_valid, 1'b0);
    checkOutput("reset_par_err", bus.par_err, 1'b0);
    checkOutput("reset_stp_err", bus.stp_err, 1'b0);
    rst_n = 1'b1;
    idle(4);

    $display("[TB] basic frame, P=8, no parity");
    applyStimulus(8'hA5, 8, 0, 0, 0, 1, 0, 0);
    idle(3);
    checkOutput("t1_latency", (got_q.size() > 0) ? got_q[0].cyc - last_start : -1, 80);
    checkEvents("t1");

    $display("[TB] even parity, P=16");
    applyStimulus(8'h3C, 16, 1, 0, 0, 1, 0, 0);
    applyStimulus(8'h3C, 16, 1, 0, 1, 1, 0, 0);
    checkEvents("t2");

    $display("[TB] odd parity, bad stop, P=32");
    applyStimulus(8'h81, 32, 1, 1, 0, 0, 0, 0);
    applyStimulus(8'h81, 32, 1, 1, 1, 0, 0, 0);
    checkEvents("t3");

    $display("[TB] start glitch then frame, P=8");
    @(negedge clk);
    bus.prescale = PW'(8);
    bus.par_en   = 1'b0;
    bus.rx_in    = 1'b0;
    repeat (2) begin
      @(negedge clk);
      bus.rx_in = 1'b0;
    end
    idle(12);
    checkEvents("t4_glitch");
    checkOutput("t4_hold", bus.p_data, last_good);
    applyStimulus(8'h55, 8, 0, 0, 0, 1, 0, 0);
    checkEvents("t4");
    checkOutput("t4_p_data", bus.p_data, 8'h55);

    $display("[TB] back-to-back frames, P=16");
    applyStimulus(8'h12, 16, 0, 0, 0, 1, 0, 0);
    applyStimulus(8'h34, 16, 0, 0, 0, 1, 0, 0);
    idle(3);
    checkOutput("t5_spacing", (got_q.size() >= 2) ? got_q[1].cyc - got_q[0].cyc : -1, 160);
    checkEvents("t5");

    $display("[TB] break condition, P=8");
    repeat (3) applyStimulus(8'h00, 8, 0, 0, 0, 0, 0, 0);
    checkEvents("brk");

    $display("[TB] reset mid-frame, then noisy frame");
    @(negedge clk);
    bus.prescale = PW'(8);
    bus.par_en   = 1'b0;
    bus.rx_in    = 1'b0;
    repeat (7) begin
      @(negedge clk);
      bus.rx_in = 1'b0;
    end
    repeat (20) begin
      @(negedge clk);
      bus.rx_in = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_p_data", bus.p_data, 8'h00);
    checkOutput("t6_rst_valid", bus.data_valid, 1'b0);
    last_good = 8'h00;
    idle(3);
    rst_n = 1'b1;
    idle(40);
    checkEvents("t6_abort");
    applyStimulus(8'h0F, 8, 0, 0, 0, 1, 1, 0);
    checkEvents("t6");
    checkOutput("t6_p_data", bus.p_data, 8'h0F);

    $display("[TB] random frames");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      pen = 1'($urandom);
      gap = $urandom_range(0, 3);
      applyStimulus(8'($urandom), p, pen, 1'($urandom), pen && ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 3) != 0, 1'($urandom), 1'b1);
      if (gap > 0) idle(gap);
    end
    checkEvents("rand");
    checkOutput("rand_p_data", bus.p_data, last_good);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
